bk_adder_pipe: RTL and testbench
================================

Name: bk_adder_pipe

Overview:
Parametrised, pipelined Brent-Kung prefix adder/subtractor. It is the successor to the fixed 8-bit combinational BrentKungAdder. Operand width, pipeline depth and add/subtract mode are generalised, and a valid/ready stream handshake is added. It sits on the modular-exponentiation datapath as the wide add/sub primitive feeding the Montgomery reduction stages.

Parameters:
- WIDTH, 32, operand width in bits; power of two, 4..256.
- STAGES, 2, pipeline register stages between input capture and output; 1..log2(WIDTH)+1.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in; used only when op_sub=0.
- op_sub  input  1  0: a+b+c_in; 1: a-b (a+~b+1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, low WIDTH bits.
- c_out  output  1  carry out of the MSB. In subtract mode this is the not-borrow: 1 when a>=b, unsigned.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock and an asynchronous active-low reset; clk and rst_n are the only clock and reset.
- Reset (rst_n=0, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - sum=0, c_out=0, ovf=0.
  - in_ready is 1 one cycle after deassertion.
  - Any beats in flight are discarded.
- Operand conditioning, in the capture cycle: b_eff = op_sub ? ~b : b; cin_eff = op_sub ? 1 : c_in.
- Datapath structure: g/p generation, then the Brent-Kung up-sweep (log2 WIDTH levels), then the down-sweep (log2 WIDTH - 1 levels), then XOR sum.
- Pipeline register placement:
  - STAGES register banks are placed at level boundaries, spread as evenly as possible.
  - Exact placement is implementation-defined.
  - Each bank carries the partial g/p, p_bit, cin_eff and a valid bit.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES, provided there is no stall. Throughput is 1 beat/cycle.
- Handshake:
  - advance = !out_valid | out_ready.
  - in_ready = advance (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When advance=0, all stages hold, including bubbles (global stall).
  - sum, c_out and ovf stay stable while out_valid=1 & out_ready=0.
- Simultaneous accept and output in the same cycle is allowed. No combinational path runs from in_valid to out_valid.
- A bubble enters the pipe when in_valid=0 and advance=1.
- in_valid=1 while in_ready=0: the beat is not taken. The source must hold it stable.
- Width rules:
  - Result is modulo 2^WIDTH.
  - c_out = bit WIDTH of the (WIDTH+1)-bit sum.
  - ovf uses the two's-complement interpretation of a and b_eff.
- Ordering: results leave in acceptance order. No beat is lost or duplicated under any in_valid/out_ready pattern.
- Reset during a stall: all pending beats are dropped; out_valid goes low immediately, asynchronously.

Test Plan:
- WIDTH=8, STAGES=2, a=0x03, b=0x01, c_in=0, op_sub=0, out_ready=1 -> after 2 edges: out_valid=1, sum=0x04, c_out=0, ovf=0.
- WIDTH=8, a=0x85, b=0x8C, c_in=0, add -> sum=0x11, c_out=1, ovf=1.
- WIDTH=8, a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1, ovf=0.
- Subtract at WIDTH=8:
  - a=0x10, b=0x20, op_sub=1 -> sum=0xF0, c_out=0.
  - a=0x20, b=0x10 -> sum=0x10, c_out=1.
  - c_in is ignored in both cases.
- Back-to-back stream at WIDTH=32, STAGES=3: 1000 random beats with in_valid=1 and out_ready toggled randomly -> outputs match a+b+c_in in order, data is stable during stalls, and in_ready equals !out_valid|out_ready every cycle.
- Reset mid-flight at WIDTH=32, STAGES=3: accept 3 beats, assert rst_n=0 between edges -> out_valid and sum drop to 0 at once. After release, the first new beat's result (0x7FFFFFFF+1 -> 0x80000000, ovf=1) is the first output; no stale beats appear.

Source files
------------

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready handshake.
// Capture bank, then the prefix levels and final XOR spread over STAGES register banks.
module bk_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int LOG = $clog2(WIDTH);
  localparam int NL  = 2*LOG - 1;   // up-sweep + down-sweep levels
  localparam int TOT = NL + 1;      // plus the final sum level

  // Bank s sits after level ceil(s*TOT/STAGES); the last bank is always the output register.
  function automatic bit is_bank(input int j);
    bit r;
    r = 1'b0;
    for (int s = 1; s <= STAGES; s++)
      if ((s*TOT + STAGES - 1) / STAGES == j) r = 1'b1;
    return r;
  endfunction

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  logic [WIDTH-1:0] b_eff, p0, g0;
  logic             cin_eff;
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub | c_in;
  assign p0      = a ^ b_eff;
  // Carry-in folded into bit 0 generate, so prefix G[i] is the carry into bit i+1.
  assign g0      = (a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & cin_eff};

  for (genvar j = 0; j <= NL; j++) begin : g_lvl
    logic [WIDTH-1:0] gq, pq, pbq;
    logic             ciq, vq;

    if (j == 0) begin : g_cap
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          gq <= '0; pq <= '0; pbq <= '0; ciq <= 1'b0; vq <= 1'b0;
        end else if (advance) begin
          gq <= g0; pq <= p0; pbq <= p0; ciq <= cin_eff; vq <= in_valid;
        end
    end else begin : g_pfx
      localparam int UP = (j <= LOG) ? 1 : 0;
      localparam int D  = (UP != 0) ? (1 << (j-1)) : (1 << (2*LOG - j - 1));
      logic [WIDTH-1:0] gc, pc;

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        localparam int ACT = (UP != 0) ? (((i+1) % (2*D)) == 0)
                                       : ((((i+1) % (2*D)) == D) && ((i+1) > 2*D));
        if (ACT != 0) begin : g_op
          assign gc[i] = g_lvl[j-1].gq[i] | (g_lvl[j-1].pq[i] & g_lvl[j-1].gq[i-D]);
          assign pc[i] = g_lvl[j-1].pq[i] & g_lvl[j-1].pq[i-D];
        end else begin : g_pass
          assign gc[i] = g_lvl[j-1].gq[i];
          assign pc[i] = g_lvl[j-1].pq[i];
        end
      end

      if (is_bank(j)) begin : g_reg
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) begin
            gq <= '0; pq <= '0; pbq <= '0; ciq <= 1'b0; vq <= 1'b0;
          end else if (advance) begin
            gq  <= gc;
            pq  <= pc;
            pbq <= g_lvl[j-1].pbq;
            ciq <= g_lvl[j-1].ciq;
            vq  <= g_lvl[j-1].vq;
          end
      end else begin : g_wire
        assign gq  = gc;
        assign pq  = pc;
        assign pbq = g_lvl[j-1].pbq;
        assign ciq = g_lvl[j-1].ciq;
        assign vq  = g_lvl[j-1].vq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
    end else if (advance) begin
      out_valid <= g_lvl[NL].vq;
      sum       <= g_lvl[NL].pbq ^ {g_lvl[NL].gq[WIDTH-2:0], g_lvl[NL].ciq};
      c_out     <= g_lvl[NL].gq[WIDTH-1];
      ovf       <= g_lvl[NL].gq[WIDTH-1] ^ g_lvl[NL].gq[WIDTH-2];
    end

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Bench for bk_adder_pipe: directed 8-bit vectors, random 32-bit stream with stalls,
// and reset in flight; results checked against an arithmetic reference queue.
module tb_bk_adder_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       iv8, ir8, ci8, sub8, ov8, or8, co8, of8;
  logic [7:0] a8, b8, s8;
  logic        iv32, ir32, ci32, sub32, ov32, or32, co32, of32;
  logic [31:0] a32, b32, s32;

  bk_adder_pipe #(.WIDTH(8), .STAGES(2)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .c_in(ci8), .op_sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(s8),
    .c_out(co8), .ovf(of8));

  bk_adder_pipe #(.WIDTH(32), .STAGES(3)) u_d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .c_in(ci32), .op_sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
    .c_out(co32), .ovf(of32));

  int n_vec = 0;
  int n_err = 0;
  logic [33:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ovf, c_out, sum} from plain (WIDTH+1)-bit arithmetic
  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sub);
    logic [31:0] be;
    logic [32:0] s;
    logic        o;
    be = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, be} + (sub ? 33'd1 : {32'd0, ci});
    o  = (a[31] == be[31]) && (s[31] != a[31]);
    return {o, s[32], s[31:0]};
  endfunction

  // Entered just after a posedge with the 8-bit pipe empty.
  task automatic beat8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    a8 = a; b8 = b; ci8 = ci; sub8 = sub; iv8 = 1'b1; or8 = 1'b1;
    #1 chk("rdy8", ir8, 1);
    @(posedge clk); #1 iv8 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("vld8", ov8, (k == 2));
      if (k == 2) chk("res8", {of8, co8, s8}, {eo, ec, es});
      @(posedge clk);
    end
    #1;
  endtask

  task automatic new_beat32();
    a32 = $urandom; b32 = $urandom; ci32 = $urandom_range(0, 1); sub32 = $urandom_range(0, 1);
  endtask

  initial begin
    int sent, got, cyc;
    logic acc;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; or8 = 1;
    iv32 = 0; a32 = 0; b32 = 0; ci32 = 0; sub32 = 0; or32 = 1;
    #1 rst_n = 1'b0;
    #10;
    chk("rst8", {ov8, co8, of8, s8}, 0);
    chk("rst32", {ov32, co32, of32, s32}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    beat8(8'h03, 8'h01, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0);
    beat8(8'h85, 8'h8C, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1);
    beat8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    beat8(8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
    beat8(8'h20, 8'h10, 1'b1, 1'b1, 8'h10, 1'b1, 1'b0);

    // random stream with random downstream stalls
    sent = 0; got = 0; cyc = 0;
    new_beat32(); iv32 = 1'b1; or32 = $urandom_range(0, 1);
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      chk("rdy32", ir32, !ov32 | or32);
      if (ov32) begin
        if (q.size() == 0) chk("spurious32", ov32, 0);
        else begin
          chk("out32", {of32, co32, s32}, q[0]);
          if (or32) begin void'(q.pop_front()); got++; end
        end
      end
      acc = iv32 & ir32;
      if (acc) begin q.push_back(ref32(a32, b32, ci32, sub32)); sent++; end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < 1000) new_beat32(); else iv32 = 1'b0;
      end
      or32 = ($urandom_range(0, 9) < 6);
    end
    chk("stream_left", (1000 - sent) + q.size(), 0);
    chk("stream_got", got, 1000);

    // reset with beats in flight
    or32 = 1'b1;
    a32 = 32'h1234_5678; b32 = 32'h0101_0101; ci32 = 0; sub32 = 0; iv32 = 1'b1;
    @(posedge clk); #1 a32 = 32'hDEAD_0000; b32 = 32'h0000_BEEF;
    @(posedge clk); #1 a32 = 32'h0000_0005; b32 = 32'h0000_0003; sub32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0; sub32 = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst", {ov32, of32, co32, s32}, {1'b1, ref32(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0)});
    rst_n = 1'b0;
    #1 chk("rst_drop", {ov32, co32, of32, s32}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rdy_after_rst", ir32, 1);
    a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001; ci32 = 0; sub32 = 0; iv32 = 1'b1;
    @(posedge clk); #1 iv32 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("post_rst_vld", ov32, (k == 3));
      if (k == 3) chk("post_rst_res", {of32, co32, s32}, {1'b1, 1'b0, 32'h8000_0000});
      @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
